// File: rtl/apb_pkg.sv
// Shared types for the APB host sequencer: mux request codes, FSM states and
// the packed command record stored in the command FIFO.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [1:0] MUX_IDLE  = 2'b00;
  localparam logic [1:0] MUX_READ  = 2'b01;
  localparam logic [1:0] MUX_WRITE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that full and
// empty are told apart without a separate counter.
module apb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge PCLK) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/apb_host_sequencer.sv
// Host command sequencer upstream of apb_master: queues commands, issues them one at a
// time on mux/addr_in/wdata_in and answers each from the APB handshake. Macro: APB_SEQ_TIMEOUT_EN.
module apb_host_sequencer
  import apb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 100
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        mux,
  output logic [ADDR_W-1:0] addr_in,
  output logic [DATA_W-1:0] wdata_in,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  output logic              busy,
  output seq_state_t        state_dbg
);

  // valid/ready: a transfer occurs on each rising edge where valid and ready are both
  // high; the sender keeps valid and its payload stable until that edge.

  seq_state_t state, state_nxt;
  apb_cmd_t   push_cmd, head_cmd;
  logic       fifo_full, fifo_empty;
  logic       push, pop, hs, timed_out, done;
  logic       cur_write;

  assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign hs        = PSEL && PENABLE && PREADY;
  assign done      = (state == WAIT) && (hs || timed_out);

  apb_cmd_fifo #(.DEPTH(DEPTH), .WIDTH($bits(apb_cmd_t))) u_fifo (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .push  (push),
    .pop   (pop),
    .din   (push_cmd),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign timed_out = (state == WAIT) && !hs && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      to_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == REQ)       to_cnt <= '0;
      else if (state == WAIT) to_cnt <= to_cnt + 1'b1;
      if (done) rsp_err <= !hs;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (hs || timed_out) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mux is non-zero only in the cycle after a pop, i.e. exactly the REQ cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      mux       <= MUX_IDLE;
      addr_in   <= '0;
      wdata_in  <= '0;
      cur_write <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      mux <= pop ? (head_cmd.write ? MUX_WRITE : MUX_READ) : MUX_IDLE;
      if (pop) begin
        addr_in   <= head_cmd.addr;
        wdata_in  <= head_cmd.wdata;
        cur_write <= head_cmd.write;
      end
      if (done) begin
        rsp_write <= cur_write;
        rsp_rdata <= (hs && !cur_write) ? PRDATA : '0;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_apb_host_sequencer.sv
// Directed bench for apb_host_sequencer with a behavioural master+slave that answers
// each mux pulse with a two-phase APB transfer against a small memory.
module tb_apb_host_sequencer;
  import apb_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  mux;
  logic [31:0] addr_in, wdata_in;
  logic        PSEL, PENABLE, PREADY;
  logic [31:0] PRDATA;
  logic        busy;
  seq_state_t  state_dbg;

  apb_host_sequencer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mux(mux), .addr_in(addr_in), .wdata_in(wdata_in),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 PCLK = ~PCLK;

  int          n_tests = 0;
  int          n_fail = 0;
  int          rsp_cnt = 0;
  int          exp_total = 0;
  logic [33:0] exp_q[$];     // {err, write, rdata}
  logic [65:0] mux_log[$];   // {mux, addr_in, wdata_in} per request pulse
  logic [1:0]  prev_mux = 2'b00;
  logic        slave_en = 1'b1;
  logic        pready_en = 1'b1;
  logic        force_hs = 1'b0;
  logic [31:0] slave_mem[4];

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input logic track);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && t < 200) begin
      @(posedge PCLK); #1; t++;
    end
    check("cmd_accept_wait", cmd_ready, 1'b1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    if (track) begin
      exp_q.push_back({exp_err, w, (w ? 32'h0 : exp_rd)});
      exp_total++;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (rsp_cnt < exp_total && t < 1000) begin
      @(posedge PCLK); #1; t++;
    end
    check("drain_done", rsp_cnt >= exp_total, 1'b1);
  endtask

  // Response scoreboard: a response is taken on the edge after this sample.
  always @(negedge PCLK) begin
    if (!PRESET && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      check("rsp_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("rsp_fields", {rsp_err, rsp_write, rsp_rdata}, exp_q.pop_front());
    end
  end

  // Request monitor: every mux pulse is logged and must be a single cycle wide.
  always @(negedge PCLK) begin
    if (!PRESET && mux != MUX_IDLE) begin
      mux_log.push_back({mux, addr_in, wdata_in});
      check("mux_one_cycle", prev_mux, MUX_IDLE);
    end
    prev_mux = mux;
  end

  // Behavioural master+slave: setup cycle after the mux pulse, then access until PREADY.
  initial begin : apb_slave
    int          ph;
    logic        sw;
    logic [31:0] sa, sd;
    ph = 0; sw = 1'b0; sa = '0; sd = '0;
    for (int i = 0; i < 4; i++) slave_mem[i] = '0;
    PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PRDATA = '0;
    forever begin
      @(posedge PCLK); #1;
      if (PRESET) ph = 0;
      else if (ph == 0) begin
        if (mux != MUX_IDLE && slave_en) begin
          sw = (mux == MUX_WRITE); sa = addr_in; sd = wdata_in; ph = 1;
        end
      end else if (ph == 1) ph = 2;
      else if (PREADY) begin
        if (sw) slave_mem[sa[3:2]] = sd;
        ph = 0;
      end
      PSEL    = (ph != 0) || force_hs;
      PENABLE = (ph == 2) || force_hs;
      PREADY  = (ph == 2 && pready_en) || force_hs;
      PRDATA  = (ph == 2 && !sw) ? slave_mem[sa[3:2]] : (force_hs ? 32'hBAD0BAD0 : 32'h0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          snap;
    int          t;
    logic [31:0] a, d;

    vecs[0] = '{1'b1, 32'h4, 32'h12345678, 32'h0};
    vecs[1] = '{1'b1, 32'h8, 32'hCAFEF00D, 32'h0};
    vecs[2] = '{1'b0, 32'h4, 32'h0, 32'h12345678};
    vecs[3] = '{1'b0, 32'h8, 32'h0, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 32'hC, 32'h00000000, 32'h0};
    vecs[5] = '{1'b0, 32'hC, 32'h0, 32'h00000000};
    vecs[6] = '{1'b1, 32'hC, 32'hFFFFFFFF, 32'h0};
    vecs[7] = '{1'b0, 32'hC, 32'h0, 32'hFFFFFFFF};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_write", rsp_write, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_mux", mux, MUX_IDLE);
    check("rst_addr_in", addr_in, 32'h0);
    check("rst_wdata_in", wdata_in, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, IDLE);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Write then read with cycle-exact request and response timing.
    mux_log.delete();
    send_cmd(1'b1, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    check("no_bypass_mux", mux, MUX_IDLE);
    check("no_bypass_busy", busy, 1'b0);
    @(posedge PCLK); #1;
    check("wr_mux", mux, MUX_WRITE);
    check("wr_addr_in", addr_in, 32'h0);
    check("wr_wdata_in", wdata_in, 32'hDEADBEEF);
    check("wr_busy", busy, 1'b1);
    @(posedge PCLK); #1;
    check("wr_mux_drop", mux, MUX_IDLE);
    check("wr_rsp_early", rsp_valid, 1'b0);
    @(posedge PCLK); #1;
    check("wr_rsp_latency", rsp_valid, 1'b1);
    wait_drain();
    send_cmd(1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    @(posedge PCLK); #1;
    check("rd_mux", mux, MUX_READ);
    wait_drain();
    check("mux_pulse_count", mux_log.size(), 2);
    if (mux_log.size() == 2) begin
      check("mux_log0", mux_log[0], {MUX_WRITE, 32'h0, 32'hDEADBEEF});
      check("mux_log1", mux_log[1], {MUX_READ, 32'h0, 32'h0});
    end
    check("addr_hold_idle", addr_in, 32'h0);

    // Table of directed commands, one outstanding at a time.
    for (int i = 0; i < 8; i++) begin
      send_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0, 1'b1);
      wait_drain();
    end

    // Fill the FIFO while the first command is stuck in RESP.
    rsp_ready = 1'b0;
    send_cmd(1'b1, 32'h0, 32'h11111111, 32'h0, 1'b0, 1'b1);
    send_cmd(1'b1, 32'h4, 32'h22222222, 32'h0, 1'b0, 1'b1);
    send_cmd(1'b1, 32'h8, 32'h33333333, 32'h0, 1'b0, 1'b1);
    send_cmd(1'b1, 32'hC, 32'h44444444, 32'h0, 1'b0, 1'b1);
    send_cmd(1'b1, 32'h0, 32'h55555555, 32'h0, 1'b0, 1'b1);
    check("fill_cmd_ready", cmd_ready, 1'b0);
    check("fill_rsp_valid", rsp_valid, 1'b1);
    check("fill_state", state_dbg, RESP);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h99999999;
    repeat (3) begin
      @(posedge PCLK); #1;
      check("full_no_accept", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();
    send_cmd(1'b0, 32'h0, 32'h0, 32'h55555555, 1'b0, 1'b1);
    send_cmd(1'b0, 32'h4, 32'h0, 32'h22222222, 1'b0, 1'b1);
    send_cmd(1'b0, 32'h8, 32'h0, 32'h33333333, 1'b0, 1'b1);
    send_cmd(1'b0, 32'hC, 32'h0, 32'h44444444, 1'b0, 1'b1);
    wait_drain();

    // Response back-pressure: fields held, no new request while in RESP.
    rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h4, 32'h0, 32'h22222222, 1'b0, 1'b1);
    send_cmd(1'b1, 32'h8, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(posedge PCLK); #1; t++;
    end
    check("bp_reach_resp", rsp_valid, 1'b1);
    mux_log.delete();
    for (int i = 0; i < 10; i++) begin
      @(posedge PCLK); #1;
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_write", rsp_write, 1'b0);
      check("bp_rdata", rsp_rdata, 32'h22222222);
    end
    check("bp_no_mux", mux_log.size(), 0);
    rsp_ready = 1'b1;
    wait_drain();

    // Handshake while idle must be ignored.
    force_hs = 1'b1;
    repeat (4) begin
      @(posedge PCLK); #1;
      check("idle_hs_rsp", rsp_valid, 1'b0);
      check("idle_hs_busy", busy, 1'b0);
    end
    force_hs = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;

`ifdef APB_SEQ_TIMEOUT_EN
    // Stalled slave: error response exactly TIMEOUT cycles after entering WAIT.
    pready_en = 1'b0;
    send_cmd(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    repeat (9) @(posedge PCLK);
    #1;
    check("to_not_yet", rsp_valid, 1'b0);
    @(posedge PCLK); #1;
    check("to_rsp_valid", rsp_valid, 1'b1);
    check("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_rdata", rsp_rdata, 32'h0);
    wait_drain();
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    pready_en = 1'b1;
`endif

    // Reset during WAIT with three commands queued.
    pready_en = 1'b0;
    send_cmd(1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0);
    send_cmd(1'b1, 32'hC, 32'hBADBAD01, 32'h0, 1'b0, 1'b0);
    send_cmd(1'b1, 32'hC, 32'hBADBAD02, 32'h0, 1'b0, 1'b0);
    send_cmd(1'b1, 32'hC, 32'hBADBAD03, 32'h0, 1'b0, 1'b0);
    check("mid_state_wait", state_dbg, WAIT);
    #2;
    PRESET = 1'b1;
    #1;
    check("mid_rst_mux", mux, MUX_IDLE);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    pready_en = 1'b1;
    snap = rsp_cnt;
    repeat (12) @(posedge PCLK);
    #1;
    check("mid_no_stale_rsp", rsp_cnt, snap);
    check("mid_idle", busy, 1'b0);
    send_cmd(1'b0, 32'h4, 32'h0, 32'h22222222, 1'b0, 1'b1);
    wait_drain();

    // Random write/read pairs.
    for (int i = 0; i < 20; i++) begin
      a = 32'($urandom_range(0, 3) * 4);
      d = $urandom;
      send_cmd(1'b1, a, d, 32'h0, 1'b0, 1'b1);
      send_cmd(1'b0, a, 32'h0, d, 1'b0, 1'b1);
      if ($urandom_range(0, 1) == 1) wait_drain();
    end
    wait_drain();
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_host_sequencer.md
# apb_host_sequencer

Command sequencer sitting directly upstream of `apb_master`. It does three things:
- accepts host read/write commands through a valid/ready FIFO;
- issues them one at a time on the master's `mux`/`addr_in`/`wdata_in` request interface;
- detects completion by monitoring the APB bus handshake, captures `PRDATA`, and returns one response per command.

It replaces bench-driven request pulses with a synthesizable, back-pressured front end.

## Interface
- `DEPTH`, 4: command FIFO entries; power of 2, at least 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 100: maximum WAIT cycles before an error response (used only when `APB_SEQ_TIMEOUT_EN` is defined).

Ports:
- `PCLK` in 1: the single clock; all logic on rising edge.
- `PRESET` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: FIFO can accept; equals !full.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: command address.
- `cmd_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: host accepts the response.
- `rsp_write` out 1: type of the completed command.
- `rsp_rdata` out DATA_W: captured `PRDATA` for reads; 0 for writes.
- `rsp_err` out 1: timeout occurred.
- `mux` out 2: request to the master; 2'b11 write, 2'b01 read, 2'b00 idle.
- `addr_in` out ADDR_W: address to the master.
- `wdata_in` out DATA_W: write data to the master.
- `PSEL`, `PENABLE`, `PREADY` in 1 each: bus monitor inputs.
- `PRDATA` in DATA_W: bus read data monitor.
- `busy` out 1: FSM not in IDLE.

## Operation
FSM states are IDLE, REQ, WAIT and RESP.
- **IDLE:** if the FIFO is not empty, pop the head at the clock edge; register `addr_in`, `wdata_in`, and `mux` (11 or 01) → REQ.
- **REQ:** `mux` holds the request for exactly one cycle; at the edge `mux` returns to 00 → WAIT.
- **WAIT:** on the first edge where `PSEL && PENABLE && PREADY`:
  - capture `PRDATA` into `rsp_rdata` for a read, or 0 for a write;
  - set `rsp_write`, set `rsp_err=0`;
  - → RESP.
- **RESP:** `rsp_valid=1`; all response fields are held stable until `rsp_valid && rsp_ready` at an edge → IDLE.

Additional rules:
- Only one transaction is outstanding at a time; the next pop happens only from IDLE.
- FIFO push occurs when `cmd_valid && cmd_ready`. When full, `cmd_ready` is low, so there is no push. A simultaneous push and pop (non-full) is legal and the count is unchanged.
- There is no bypass: a command pushed into an empty FIFO is popped on the following edge.
- FIFO read and write pointers are log2(DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- Outputs `addr_in` and `wdata_in` hold their last issued values while idle.

## Timing
- **Reset values:** `cmd_ready=1`, `rsp_valid=0`, `rsp_write=0`, `rsp_rdata=0`, `rsp_err=0`, `mux=2'b00`, `addr_in=0`, `wdata_in=0`, `busy=0`, FIFO empty, state IDLE, timeout counter 0.
- **Command latency:** command accepted at edge N → `mux` non-zero during cycle N+1 to N+2 (one cycle) → `mux=00` from N+2.
- **Response latency:** handshake sampled at edge M → `rsp_valid` high from M. Minimum back-to-back issue is one command every 2 cycles plus the bus time plus the response wait.
- **`busy`:** high in REQ, WAIT and RESP.
- **Reset mid-transaction:** the FIFO is flushed, any pending response is discarded, and `mux` is forced to 00 immediately (asynchronous).
- **Bus activity outside WAIT:** a handshake seen in REQ, IDLE or RESP is ignored.

## Configuration
- **`APB_SEQ_TIMEOUT_EN` defined:**
  - a counter increments each WAIT cycle;
  - when it reaches `TIMEOUT` without a handshake → RESP with `rsp_err=1` and `rsp_rdata=0`;
  - the counter clears on entry to WAIT.
- **`APB_SEQ_TIMEOUT_EN` not defined:** there is no counter, WAIT waits indefinitely, and `rsp_err` is tied to 0.

## Structure
- **Package `apb_pkg`:**
  - `mux` encodings: `MUX_IDLE` 2'b00, `MUX_READ` 2'b01, `MUX_WRITE` 2'b11;
  - the `seq_state_t` enum (IDLE, REQ, WAIT, RESP);
  - a packed command struct {write, addr, wdata}.
- **Sub-module `apb_cmd_fifo`:** synchronous FIFO parameterized on DEPTH and entry width, with push/pop/full/empty outputs. The sequencer instantiates one.

## Test plan
- **Write then read:** write 0x00 ← 0xDEADBEEF, then read 0x00. Require:
  - `mux` = 11 for exactly one cycle, then 01 for exactly one cycle;
  - responses in order: (write=1, rdata=0, err=0) then (write=0, rdata=0xDEADBEEF, err=0).
- **Fill FIFO:** with `rsp_ready=0`, push 5 writes to 0x0/0x4/0x8/0xC/0x0 with DEPTH=4. Require:
  - `cmd_ready` low after 4 commands are queued while the first is stuck in RESP;
  - releasing `rsp_ready` drains all 5 commands in order, each data value read back correctly afterward.
- **Response back-pressure:** hold `rsp_ready=0` for 10 cycles during RESP. Require `rsp_rdata`, `rsp_write` and `rsp_valid` stable throughout, and no new `mux` pulse.
- **Timeout (`APB_SEQ_TIMEOUT_EN`, TIMEOUT=8):** slave ties `PREADY=0`. Require a response with `rsp_err=1` and `rsp_rdata=0` exactly 8 cycles after entering WAIT.
- **Mid-transaction reset:** assert `PRESET` during WAIT with 3 commands queued. Require:
  - `mux=00`, `rsp_valid=0` and `cmd_ready=1` immediately;
  - after release, no stale responses, and a new read of 0x04 completes normally.
- **Randomized traffic:** 20 random write/read pairs to addresses 0,4,8,12 with random data. Every read response matches the preceding write, with zero errors.
